dp_control_seq: RTL and testbench

- Multi-cycle control sequencer that drives the 8x16 register file port (AA, BA, DA, RW) and the function unit / memory-mux selects of the simple datapath.
- Fetches 16-bit instructions over a request/valid handshake, decodes them, and issues one register-file transaction per instruction.
- Owns the program counter, conditional branches, jump and halt.

---
 rtl/dp_control_seq_pkg.sv | 37 +++
 rtl/dp_control_seq_if.sv | 23 ++
 rtl/dp_control_seq_decoder.sv | 69 ++++++
 rtl/dp_control_seq.sv | 128 ++++++++++++
 tb/tb_dp_control_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dp_control_seq_pkg.sv
// Shared constants for the datapath control sequencer: opcodes,
// function-unit select codes and the sequencer state encoding.
package dp_ctrl_pkg;

    localparam logic [3:0] OP_MOVA = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_ADI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BRZ  = 4'hB;
    localparam logic [3:0] OP_BRN  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] FS_MOVA = 4'h0;
    localparam logic [3:0] FS_INC  = 4'h1;
    localparam logic [3:0] FS_ADD  = 4'h2;
    localparam logic [3:0] FS_SUB  = 4'h3;
    localparam logic [3:0] FS_AND  = 4'h4;
    localparam logic [3:0] FS_OR   = 4'h5;
    localparam logic [3:0] FS_XOR  = 4'h6;
    localparam logic [3:0] FS_NOT  = 4'h7;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b10
    } state_t;

endpackage

// File: rtl/dp_control_seq_if.sv
// Instruction fetch channel: request/valid handshake plus the fetch address.
interface dp_control_seq_if #(
    parameter int PC_W = 8
);
    logic [15:0]     IR_DATA;
    logic            IR_VALID;
    logic            IR_REQ;
    logic [PC_W-1:0] PC;

    modport master (
        input  IR_DATA,
        input  IR_VALID,
        output IR_REQ,
        output PC
    );

    modport slave (
        output IR_DATA,
        output IR_VALID,
        input  IR_REQ,
        input  PC
    );
endinterface

// File: rtl/dp_control_seq_decoder.sv
// Combinational instruction decoder. RW/MW are raw; the sequencer gates them
// so that writes only happen during the execute cycle.
module dp_instr_decoder
    import dp_ctrl_pkg::*;
#(
    parameter int IMM_W = 3
) (
    input  logic [15:0] ir_i,
    output logic [2:0]  aa_o,
    output logic [2:0]  ba_o,
    output logic [2:0]  da_o,
    output logic [3:0]  fs_o,
    output logic        mb_o,
    output logic        md_o,
    output logic        rw_o,
    output logic        mw_o,
    output logic        is_brz_o,
    output logic        is_brn_o,
    output logic        is_jmp_o,
    output logic        is_hlt_o,
    output logic [15:0] const_o
);

    logic [3:0] op_s;

    assign op_s    = ir_i[15:12];
    assign da_o    = ir_i[8:6];
    assign aa_o    = ir_i[5:3];
    assign ba_o    = ir_i[2:0];
    assign const_o = {{(16-IMM_W){1'b0}}, ir_i[IMM_W-1:0]};

    // Opcode to control-word mapping
    always_comb begin
        fs_o     = FS_MOVA;
        mb_o     = 1'b0;
        md_o     = 1'b0;
        rw_o     = 1'b0;
        mw_o     = 1'b0;
        is_brz_o = 1'b0;
        is_brn_o = 1'b0;
        is_jmp_o = 1'b0;
        is_hlt_o = 1'b0;
        case (op_s)
            OP_MOVA, OP_INC, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                // ALU opcodes share their encoding with the FS code
                fs_o = op_s;
                rw_o = 1'b1;
            end
            OP_ADI: begin
                fs_o = FS_ADD;
                mb_o = 1'b1;
                rw_o = 1'b1;
            end
            OP_LD: begin
                md_o = 1'b1;
                rw_o = 1'b1;
            end
            OP_ST:   mw_o     = 1'b1;
            OP_BRZ:  is_brz_o = 1'b1;
            OP_BRN:  is_brn_o = 1'b1;
            OP_JMP:  is_jmp_o = 1'b1;
            OP_NOP:  fs_o     = FS_MOVA;
            OP_HLT:  is_hlt_o = 1'b1;
            default: fs_o     = FS_MOVA;
        endcase
    end

endmodule

// File: rtl/dp_control_seq.sv
// Fetch/execute control sequencer for the simple datapath: owns PC and IR,
// issues one register-file transaction per instruction, handles branch/jump/halt.
module dp_control_seq
    import dp_ctrl_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IMM_W = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    dp_control_seq_if.master    fetch,
    input  logic [PC_W-1:0]     A_DATA,
    input  logic                Z,
    input  logic                N,
    output logic [2:0]          AA,
    output logic [2:0]          BA,
    output logic [2:0]          DA,
    output logic                RW,
    output logic                MW,
    output logic                MB,
    output logic                MD,
    output logic [3:0]          FS,
    output logic [15:0]         CONST_OUT,
    output logic                HALTED
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [3:0]      dec_fs_s;
    logic            dec_mb_s, dec_md_s, dec_rw_s, dec_mw_s;
    logic            is_brz_s, is_brn_s, is_jmp_s, is_hlt_s;
    logic [PC_W-1:0] pc_inc_s, pc_br_s;
    logic [5:0]      br_off_s;
    logic            ir_req_s;

    dp_instr_decoder #(.IMM_W(IMM_W)) u_dec (
        .ir_i     (ir_q),
        .aa_o     (AA),
        .ba_o     (BA),
        .da_o     (DA),
        .fs_o     (dec_fs_s),
        .mb_o     (dec_mb_s),
        .md_o     (dec_md_s),
        .rw_o     (dec_rw_s),
        .mw_o     (dec_mw_s),
        .is_brz_o (is_brz_s),
        .is_brn_o (is_brn_s),
        .is_jmp_o (is_jmp_s),
        .is_hlt_o (is_hlt_s),
        .const_o  (CONST_OUT)
    );

    // Branch displacement is the signed 6-bit {DR,SB}; PC math wraps silently
    assign br_off_s = {ir_q[8:6], ir_q[2:0]};
    assign pc_inc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_br_s  = pc_q + {{(PC_W-6){br_off_s[5]}}, br_off_s};

    assign fetch.IR_REQ = ir_req_s;
    assign fetch.PC     = pc_q;

    // State, PC and IR registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
            pc_q    <= {PC_W{1'b0}};
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, PC update and gated control outputs
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_req_s = 1'b0;
        RW       = 1'b0;
        MW       = 1'b0;
        MB       = 1'b0;
        MD       = 1'b0;
        FS       = FS_MOVA;
        HALTED   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_req_s = 1'b1;
                if (fetch.IR_VALID) begin
                    ir_d    = fetch.IR_DATA;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                RW = dec_rw_s;
                MW = dec_mw_s;
                MB = dec_mb_s;
                MD = dec_md_s;
                FS = dec_fs_s;
                if (is_hlt_s) begin
                    state_d = S_HALT;
                end else if (is_jmp_s) begin
                    pc_d    = A_DATA;
                    state_d = S_FETCH;
                end else if (is_brz_s) begin
                    pc_d    = Z ? pc_br_s : pc_inc_s;
                    state_d = S_FETCH;
                end else if (is_brn_s) begin
                    pc_d    = N ? pc_br_s : pc_inc_s;
                    state_d = S_FETCH;
                end else begin
                    pc_d    = pc_inc_s;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                HALTED  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_dp_control_seq.sv
// Directed, table-driven bench for dp_control_seq with hand-computed expectations.
module tb_dp_control_seq;
    import dp_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  a_data;
    logic        z, n;
    logic [2:0]  aa, ba, da;
    logic        rw, mw, mb, md;
    logic [3:0]  fs;
    logic [15:0] const_out;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;

    dp_control_seq_if #(.PC_W(8)) fif ();

    dp_control_seq #(.PC_W(8), .IMM_W(3)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .fetch     (fif.master),
        .A_DATA    (a_data),
        .Z         (z),
        .N         (n),
        .AA        (aa),
        .BA        (ba),
        .DA        (da),
        .RW        (rw),
        .MW        (mw),
        .MB        (mb),
        .MD        (md),
        .FS        (fs),
        .CONST_OUT (const_out),
        .HALTED    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] instr;
        logic        z;
        logic        n;
        logic [7:0]  adata;
        logic [2:0]  aa, ba, da;
        logic [3:0]  fs;
        logic        rw, mw, mb, md;
        logic [15:0] cst;
        logic [7:0]  pc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic [15:0] instr, input logic zz, input logic nn,
                                input logic [7:0] ad, input logic [2:0] eaa, input logic [2:0] eba,
                                input logic [2:0] eda, input logic [3:0] efs, input logic erw,
                                input logic emw, input logic emb, input logic emd,
                                input logic [15:0] ec, input logic [7:0] epc);
        vec_t v;
        v.instr = instr; v.z = zz; v.n = nn; v.adata = ad;
        v.aa = eaa; v.ba = eba; v.da = eda; v.fs = efs;
        v.rw = erw; v.mw = emw; v.mb = emb; v.md = emd;
        v.cst = ec; v.pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left at a negedge with the sequencer in S_FETCH
    task automatic run_vec(input int idx, input int wait_cyc);
        vec_t v;
        v = vecs[idx];
        repeat (wait_cyc) @(negedge clk);
        fif.IR_DATA  = v.instr;
        fif.IR_VALID = 1'b1;
        z = v.z; n = v.n; a_data = v.adata;
        @(negedge clk);
        fif.IR_VALID = 1'b0;
        chk($sformatf("exec[%0d]", idx),
            {30'd0, aa, ba, da, fs, rw, mw, mb, md, const_out, halted},
            {30'd0, v.aa, v.ba, v.da, v.fs, v.rw, v.mw, v.mb, v.md, v.cst, 1'b0});
        @(negedge clk);
        chk($sformatf("post[%0d] pc/req/rw/mw", idx),
            {52'd0, fif.PC, fif.IR_REQ, rw, mw, halted},
            {52'd0, v.pc, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        rst = 1'b1;
        fif.IR_DATA = 16'h0000; fif.IR_VALID = 1'b0;
        a_data = 8'h00; z = 1'b0; n = 1'b0;

        //           instr    z     n     adata  aa    ba    da    fs       rw    mw    mb    md    const    pc
        vecs[0]  = mk(16'h2053, 1'b0, 1'b0, 8'h00, 3'd2, 3'd3, 3'd1, FS_ADD,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 8'h01);
        vecs[1]  = mk(16'h8097, 1'b0, 1'b0, 8'h00, 3'd2, 3'd7, 3'd2, FS_ADD,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 8'h02);
        vecs[2]  = mk(16'h9040, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd1, FS_MOVA, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h03);
        vecs[3]  = mk(16'hA01A, 1'b0, 1'b0, 8'h00, 3'd3, 3'd2, 3'd0, FS_MOVA, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 8'h04);
        vecs[4]  = mk(16'h31D1, 1'b0, 1'b0, 8'h00, 3'd2, 3'd1, 3'd7, FS_SUB,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 8'h05);
        vecs[5]  = mk(16'h6088, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0, 3'd2, FS_XOR,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h06);
        vecs[6]  = mk(16'h4E53, 1'b1, 1'b1, 8'h00, 3'd2, 3'd3, 3'd1, FS_AND,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 8'h07);
        vecs[7]  = mk(16'hD000, 1'b0, 1'b0, 8'h02, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02);
        vecs[8]  = mk(16'hB1C4, 1'b1, 1'b0, 8'h00, 3'd0, 3'd4, 3'd7, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 8'hFE);
        vecs[9]  = mk(16'hE000, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hFF);
        vecs[10] = mk(16'hE000, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        vecs[11] = mk(16'hE000, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h01);
        vecs[12] = mk(16'hE000, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02);
        vecs[13] = mk(16'hB1C4, 1'b0, 1'b1, 8'h00, 3'd0, 3'd4, 3'd7, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 8'h03);
        vecs[14] = mk(16'hD000, 1'b0, 1'b0, 8'h02, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02);
        vecs[15] = mk(16'hC1C4, 1'b0, 1'b1, 8'h00, 3'd0, 3'd4, 3'd7, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 8'hFE);
        vecs[16] = mk(16'hD000, 1'b0, 1'b0, 8'h02, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02);
        vecs[17] = mk(16'hC1C4, 1'b1, 1'b0, 8'h00, 3'd0, 3'd4, 3'd7, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 8'h03);
        vecs[18] = mk(16'hD000, 1'b0, 1'b0, 8'h40, 3'd0, 3'd0, 3'd0, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h40);
        vecs[19] = mk(16'h1250, 1'b0, 1'b0, 8'h00, 3'd2, 3'd0, 3'd1, FS_INC,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h41);
        vecs[20] = mk(16'h71FF, 1'b0, 1'b0, 8'h00, 3'd7, 3'd7, 3'd7, FS_NOT,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 8'h42);
        vecs[21] = mk(16'h502C, 1'b0, 1'b0, 8'h00, 3'd5, 3'd4, 3'd0, FS_OR,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 8'h43);
        vecs[22] = mk(16'h0148, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0, 3'd5, FS_MOVA, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h44);

        // Reset, then idle fetch: request held, nothing else moves
        do_reset();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("idle[%0d]", c),
                {44'd0, fif.IR_REQ, fif.PC, rw, mw, mb, md, fs, aa, ba, da, halted},
                {44'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, FS_MOVA, 3'd0, 3'd0, 3'd0, 1'b0});
            @(negedge clk);
        end

        for (int i = 0; i < 23; i++) run_vec(i, i % 3);

        // HLT at PC=0x44: freezes everything, IR_VALID ignored
        fif.IR_DATA = 16'hF000; fif.IR_VALID = 1'b1;
        @(negedge clk);
        chk("hlt exec rw/mw", {62'd0, rw, mw}, {62'd0, 1'b0, 1'b0});
        fif.IR_DATA = 16'h2053;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("halt[%0d]", c),
                {52'd0, halted, fif.IR_REQ, fif.PC, rw, mw},
                {52'd0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0});
        end
        fif.IR_VALID = 1'b0;

        // Reset out of halt, then jump to 0x12
        do_reset();
        chk("reset from halt", {60'd0, halted, fif.IR_REQ, fif.PC == 8'h00, rw},
            {60'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        fif.IR_DATA = 16'hD000; fif.IR_VALID = 1'b1; a_data = 8'h12;
        @(negedge clk);
        fif.IR_VALID = 1'b0;
        @(negedge clk);
        chk("jmp 0x12", {55'd0, fif.IR_REQ, fif.PC}, {55'd0, 1'b1, 8'h12});

        // Reset coinciding with a valid handshake must win
        fif.IR_DATA = 16'h2053; fif.IR_VALID = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; fif.IR_VALID = 1'b0;
        chk("reset mid-fetch", {50'd0, fif.IR_REQ, fif.PC, halted, rw, fs},
            {50'd0, 1'b1, 8'h00, 1'b0, 1'b0, FS_MOVA});
        @(negedge clk);
        chk("no exec after reset", {60'd0, fif.IR_REQ, rw, fif.PC[1:0]},
            {60'd0, 1'b1, 1'b0, 2'b00});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
